rx_cmd_parser: RTL and testbench
================================

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 Parameter DATA_W, default 16, payload/register width in bits; SHALL be a multiple of 8 in 8..32; NB = DATA_W/8.
REQ-002 Parameter NUM_CH, default 2, number of output channels, 1..16.
REQ-003 Parameter TIMEOUT, default 100000, maximum idle clk cycles between bytes of one frame, >= 2.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_data  in  8  received byte from the UART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
REQ-008 set_min, set_max, dc_input  out  NUM_CH*DATA_W each  per-channel registers; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-009 ramp_enable, dc_enable  out  NUM_CH each  per-channel run enables.
REQ-010 read_length  out  DATA_W; read_ch  out  4  last read request.
REQ-011 read_start  out  1  one-cycle pulse when read_length/read_ch update.
REQ-012 pong  out  8; pong_trig  out  1  ping echo byte and its one-cycle pulse.
REQ-013 cmd_done  out  1  one-cycle pulse per committed frame.
REQ-014 err  out  1  one-cycle pulse; err_code  out  2  cause, held until the next err.
REQ-015 busy  out  1  high while a frame is partially received.

Function
REQ-016 Frame format SHALL be: header byte {opcode[7:4], ch[3:0]}, then payload bytes (LSB first), then a checksum byte equal to the XOR of all preceding frame bytes.
REQ-017 Payload length SHALL be: opcode 1 PING = 1 byte; 2 SET_MIN, 3 SET_MAX, 4 DC_INPUT, 7 READ_RAMP, 8 READ_DC = NB bytes; 5 RUN_RAMP, 6 RUN_DC, 9 STOP = 0 bytes.
REQ-018 FSM states SHALL be IDLE, PAYLOAD, CHECK; IDLE->PAYLOAD on a valid header with payload, IDLE->CHECK on a valid header without payload, PAYLOAD->CHECK after the last payload byte, CHECK->IDLE on the checksum byte.
REQ-019 A header with opcode 0 or >9, or ch >= NUM_CH, SHALL pulse err with err_code=1 and leave the FSM in IDLE (byte discarded).
REQ-020 Checksum mismatch SHALL pulse err with err_code=2 and leave all registers unchanged.
REQ-021 In PAYLOAD/CHECK, TIMEOUT consecutive cycles without rx_valid SHALL pulse err with err_code=3 and return to IDLE; the counter SHALL clear on every accepted byte.
REQ-022 On a good checksum, commit SHALL occur on the clk edge that accepts the checksum byte; outputs and the cmd_done pulse SHALL be visible the following cycle.
REQ-023 Commit effects on channel c: SET_MIN -> set_min[c]=payload, dc_enable[c]=0; SET_MAX -> set_max[c]=payload, dc_enable[c]=0; DC_INPUT -> dc_input[c]=payload, ramp_enable[c]=0.
REQ-024 RUN_RAMP -> ramp_enable[c]=1, dc_enable[c]=0, dc_input[c]=0; RUN_DC -> dc_enable[c]=1, ramp_enable[c]=0, set_min[c]=set_max[c]=0; STOP -> both enables of c =0.
REQ-025 READ_RAMP/READ_DC -> read_length=payload, read_ch=c, read_start pulse, ramp_enable[c]=0 and dc_enable[c]=0 respectively.
REQ-026 PING -> pong=payload byte, pong_trig pulse.
REQ-027 Other channels and unaffected outputs SHALL hold their values at every commit.
REQ-028 A byte arriving the cycle after commit SHALL be parsed as a new header with no lost cycles.
REQ-029 err and cmd_done SHALL never pulse in the same cycle.

Reset
REQ-030 On rst all outputs, registers, FSM (IDLE), byte index, checksum accumulator and timeout counter SHALL clear to 0 immediately; a partial frame in progress SHALL be discarded without err.

Verification (DATA_W=16, NUM_CH=2, TIMEOUT=50)
REQ-031 Bytes 0x21,0x34,0x12,0x07 -> set_min ch1=0x1234, dc_enable[1]=0, one cmd_done pulse, ch0 unchanged.
REQ-032 Bytes 0x21,0x34,0x12,0x08 -> err pulse, err_code=2, set_min unchanged, no cmd_done.
REQ-033 Bytes 0x10,0xA5,0xB5 -> pong=0xA5, pong_trig high exactly one cycle.
REQ-034 Bytes 0x50,0x50 then 0x60,0x60 -> ramp_enable=01 then ramp_enable=00, dc_enable=01, set_min/set_max ch0=0.
REQ-035 Bytes 0x30,0x11 then 50 idle cycles -> err_code=3, busy low; next frame 0x70,0x08,0x00,0x78 -> read_length=0x0008, read_ch=0, read_start pulse.
REQ-036 Header 0x22 -> err_code=1; rst asserted after 0x21,0x34 -> all outputs 0, following frame parsed correctly.

Source files
------------

// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: byte-stream command decoder for a UART receiver.
// A frame is {opcode,ch} header, LSB-first payload, then an XOR checksum.
// Good frames commit to the per-channel registers on the edge that accepts
// the checksum byte. Bad headers, bad checksums and inter-byte timeouts
// raise err with a cause code.
module rx_cmd_parser #(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [NUM_CH*DATA_W-1:0] set_min,
  output logic [NUM_CH*DATA_W-1:0] set_max,
  output logic [NUM_CH*DATA_W-1:0] dc_input,
  output logic [NUM_CH-1:0]        ramp_enable,
  output logic [NUM_CH-1:0]        dc_enable,
  output logic [DATA_W-1:0]        read_length,
  output logic [3:0]               read_ch,
  output logic                     read_start,
  output logic [7:0]               pong,
  output logic                     pong_trig,
  output logic                     cmd_done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic                     busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(NB + 1);
  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [3:0] OP_PING      = 4'd1;
  localparam logic [3:0] OP_SET_MIN   = 4'd2;
  localparam logic [3:0] OP_SET_MAX   = 4'd3;
  localparam logic [3:0] OP_DC_INPUT  = 4'd4;
  localparam logic [3:0] OP_RUN_RAMP  = 4'd5;
  localparam logic [3:0] OP_RUN_DC    = 4'd6;
  localparam logic [3:0] OP_READ_RAMP = 4'd7;
  localparam logic [3:0] OP_READ_DC   = 4'd8;
  localparam logic [3:0] OP_STOP      = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [3:0]         op_r, ch_r;
  logic [IDX_W-1:0]   len_r, idx_r;
  logic [DATA_W-1:0]  payload_r;
  logic [7:0]         sum_r;
  logic [TMO_W-1:0]   tmo_r;
  logic               hdr_ok_s, tmo_hit_s;
  logic               hdr_accept_s, bad_hdr_s, pay_byte_s;
  logic               commit_s, bad_sum_s, timeout_s;

  // Number of payload bytes carried by each opcode.
  function automatic logic [IDX_W-1:0] payload_len(input logic [3:0] op);
    case (op)
      OP_PING:    payload_len = IDX_W'(1);
      OP_SET_MIN, OP_SET_MAX, OP_DC_INPUT,
      OP_READ_RAMP, OP_READ_DC: payload_len = IDX_W'(NB);
      default:    payload_len = '0;
    endcase
  endfunction

  function automatic logic opcode_ok(input logic [3:0] op);
    return (op >= OP_PING) && (op <= OP_STOP);
  endfunction

  // Running XOR checksum over the frame bytes.
  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign hdr_ok_s  = opcode_ok(rx_data[7:4]) && ({28'd0, rx_data[3:0]} < $unsigned(NUM_CH));
  assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT - 1));

  // State register; busy mirrors "not idle".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != IDLE);
    end
  end

  // Next-state logic and one-cycle event strobes.
  always_comb begin
    state_next_s = state_r;
    hdr_accept_s = 1'b0;
    bad_hdr_s    = 1'b0;
    pay_byte_s   = 1'b0;
    commit_s     = 1'b0;
    bad_sum_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          if (hdr_ok_s) begin
            hdr_accept_s = 1'b1;
            state_next_s = (payload_len(rx_data[7:4]) == '0) ? CHECK : PAYLOAD;
          end else begin
            bad_hdr_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          pay_byte_s = 1'b1;
          if (idx_r == len_r - IDX_W'(1)) begin
            state_next_s = CHECK;
          end else begin
            state_next_s = PAYLOAD;
          end
        end else if (tmo_hit_s) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = PAYLOAD;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          state_next_s = IDLE;
          if (sum_r == rx_data) begin
            commit_s = 1'b1;
          end else begin
            bad_sum_s = 1'b1;
          end
        end else if (tmo_hit_s) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = CHECK;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Idle-cycle counter: cleared on every byte and whenever the parser is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_r <= '0;
    end else if (rx_valid || (state_next_s == IDLE)) begin
      tmo_r <= '0;
    end else begin
      tmo_r <= tmo_r + TMO_W'(1);
    end
  end

  // Frame capture: header fields, payload bytes and checksum accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 4'd0;
      ch_r      <= 4'd0;
      len_r     <= '0;
      idx_r     <= '0;
      payload_r <= '0;
      sum_r     <= 8'd0;
    end else if (hdr_accept_s) begin
      op_r      <= rx_data[7:4];
      ch_r      <= rx_data[3:0];
      len_r     <= payload_len(rx_data[7:4]);
      idx_r     <= '0;
      payload_r <= '0;
      sum_r     <= rx_data;
    end else if (pay_byte_s) begin
      for (int b = 0; b < NB; b++) begin
        if (idx_r == IDX_W'(b)) payload_r[b*8 +: 8] <= rx_data;
      end
      idx_r <= idx_r + IDX_W'(1);
      sum_r <= xor_acc(sum_r, rx_data);
    end
  end

  // Output registers: commit effects, status pulses and the held error cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_min     <= '0;
      set_max     <= '0;
      dc_input    <= '0;
      ramp_enable <= '0;
      dc_enable   <= '0;
      read_length <= '0;
      read_ch     <= 4'd0;
      read_start  <= 1'b0;
      pong        <= 8'd0;
      pong_trig   <= 1'b0;
      cmd_done    <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      read_start <= 1'b0;
      pong_trig  <= 1'b0;
      cmd_done   <= commit_s;
      err        <= bad_hdr_s | bad_sum_s | timeout_s;
      if (bad_hdr_s)      err_code <= 2'd1;
      else if (bad_sum_s) err_code <= 2'd2;
      else if (timeout_s) err_code <= 2'd3;
      if (commit_s) begin
        if (op_r == OP_PING) begin
          pong      <= payload_r[7:0];
          pong_trig <= 1'b1;
        end
        if ((op_r == OP_READ_RAMP) || (op_r == OP_READ_DC)) begin
          read_length <= payload_r;
          read_ch     <= ch_r;
          read_start  <= 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_r == 4'(c)) begin
            case (op_r)
              OP_SET_MIN: begin
                set_min[c*DATA_W +: DATA_W] <= payload_r;
                dc_enable[c]                <= 1'b0;
              end
              OP_SET_MAX: begin
                set_max[c*DATA_W +: DATA_W] <= payload_r;
                dc_enable[c]                <= 1'b0;
              end
              OP_DC_INPUT: begin
                dc_input[c*DATA_W +: DATA_W] <= payload_r;
                ramp_enable[c]               <= 1'b0;
              end
              OP_RUN_RAMP: begin
                ramp_enable[c]               <= 1'b1;
                dc_enable[c]                 <= 1'b0;
                dc_input[c*DATA_W +: DATA_W] <= '0;
              end
              OP_RUN_DC: begin
                dc_enable[c]                <= 1'b1;
                ramp_enable[c]              <= 1'b0;
                set_min[c*DATA_W +: DATA_W] <= '0;
                set_max[c*DATA_W +: DATA_W] <= '0;
              end
              OP_STOP: begin
                ramp_enable[c] <= 1'b0;
                dc_enable[c]   <= 1'b0;
              end
              OP_READ_RAMP: ramp_enable[c] <= 1'b0;
              OP_READ_DC:   dc_enable[c]   <= 1'b0;
              default:      ramp_enable[c] <= ramp_enable[c];
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed bench for rx_cmd_parser (DATA_W=16, NUM_CH=2, TIMEOUT=50).
// A table of frames with hand-computed expected register state, followed by
// hand-written sequences for back-to-back frames, timeout and mid-frame reset.
module tb_rx_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] set_min, set_max, dc_input;
  logic [1:0]  ramp_enable, dc_enable;
  logic [15:0] read_length;
  logic [3:0]  read_ch;
  logic        read_start;
  logic [7:0]  pong;
  logic        pong_trig, cmd_done, err;
  logic [1:0]  err_code;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  rx_cmd_parser #(.DATA_W(16), .NUM_CH(2), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .set_min(set_min), .set_max(set_max), .dc_input(dc_input),
    .ramp_enable(ramp_enable), .dc_enable(dc_enable),
    .read_length(read_length), .read_ch(read_ch), .read_start(read_start),
    .pong(pong), .pong_trig(pong_trig), .cmd_done(cmd_done),
    .err(err), .err_code(err_code), .busy(busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [7:0]  b [4];
    logic [31:0] mn, mx, dc;
    logic [1:0]  ramp, dcen;
    logic [15:0] rlen;
    logic [3:0]  rch;
    logic [7:0]  png;
    logic        done, er;
    logic [1:0]  code;
    logic        rs, pt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [7:0] b0, b1, b2, b3,
                     input logic [31:0] mn, mx, dc, input logic [1:0] ramp, dcen,
                     input logic [15:0] rlen, input logic [3:0] rch, input logic [7:0] png,
                     input logic done, er, input logic [1:0] code, input logic rs, pt);
    vec_t v;
    v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.mn = mn; v.mx = mx; v.dc = dc; v.ramp = ramp; v.dcen = dcen;
    v.rlen = rlen; v.rch = rch; v.png = png; v.done = done; v.er = er;
    v.code = code; v.rs = rs; v.pt = pt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, ".set_min"}, 64'(set_min), 64'(v.mn));
    chk({t, ".set_max"}, 64'(set_max), 64'(v.mx));
    chk({t, ".dc_input"}, 64'(dc_input), 64'(v.dc));
    chk({t, ".ramp_enable"}, 64'(ramp_enable), 64'(v.ramp));
    chk({t, ".dc_enable"}, 64'(dc_enable), 64'(v.dcen));
    chk({t, ".read_length"}, 64'(read_length), 64'(v.rlen));
    chk({t, ".read_ch"}, 64'(read_ch), 64'(v.rch));
    chk({t, ".pong"}, 64'(pong), 64'(v.png));
    chk({t, ".cmd_done"}, 64'(cmd_done), 64'(v.done));
    chk({t, ".err"}, 64'(err), 64'(v.er));
    chk({t, ".err_code"}, 64'(err_code), 64'(v.code));
    chk({t, ".read_start"}, 64'(read_start), 64'(v.rs));
    chk({t, ".pong_trig"}, 64'(pong_trig), 64'(v.pt));
    chk({t, ".busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  k;
    logic seen;
    vec_t zero_v;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    //   n  bytes                    set_min       set_max       dc_input     ramp  dcen  rlen      rch   pong   done er code rs pt
    add(4, 8'h21,8'h34,8'h12,8'h07, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0000, 4'd0, 8'h00, 1,0,2'd0,0,0);
    add(4, 8'h21,8'h34,8'h12,8'h08, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0000, 4'd0, 8'h00, 0,1,2'd2,0,0);
    add(3, 8'h10,8'hA5,8'hB5,8'h00, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,1);
    add(4, 8'h30,8'hEF,8'hBE,8'h61, 32'h12340000, 32'h0000BEEF, 32'h00000000, 2'd0, 2'd0, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,0);
    add(4, 8'h20,8'h02,8'h01,8'h23, 32'h12340102, 32'h0000BEEF, 32'h00000000, 2'd0, 2'd0, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,0);
    add(2, 8'h50,8'h50,8'h00,8'h00, 32'h12340102, 32'h0000BEEF, 32'h00000000, 2'd1, 2'd0, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,0);
    add(4, 8'h41,8'h55,8'h55,8'h41, 32'h12340102, 32'h0000BEEF, 32'h55550000, 2'd1, 2'd0, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,0);
    add(2, 8'h60,8'h60,8'h00,8'h00, 32'h12340000, 32'h00000000, 32'h55550000, 2'd0, 2'd1, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,0);
    add(2, 8'h51,8'h51,8'h00,8'h00, 32'h12340000, 32'h00000000, 32'h00000000, 2'd2, 2'd1, 16'h0000, 4'd0, 8'hA5, 1,0,2'd2,0,0);
    add(4, 8'h80,8'h08,8'h00,8'h88, 32'h12340000, 32'h00000000, 32'h00000000, 2'd2, 2'd0, 16'h0008, 4'd0, 8'hA5, 1,0,2'd2,1,0);
    add(4, 8'h71,8'h00,8'h01,8'h70, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0100, 4'd1, 8'hA5, 1,0,2'd2,1,0);
    add(1, 8'h22,8'h00,8'h00,8'h00, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0100, 4'd1, 8'hA5, 0,1,2'd1,0,0);
    add(1, 8'h00,8'h00,8'h00,8'h00, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0100, 4'd1, 8'hA5, 0,1,2'd1,0,0);
    add(1, 8'hA0,8'h00,8'h00,8'h00, 32'h12340000, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 16'h0100, 4'd1, 8'hA5, 0,1,2'd1,0,0);
    add(2, 8'h61,8'h61,8'h00,8'h00, 32'h00000000, 32'h00000000, 32'h00000000, 2'd0, 2'd2, 16'h0100, 4'd1, 8'hA5, 1,0,2'd1,0,0);
    add(4, 8'h31,8'hFF,8'hFF,8'h31, 32'h00000000, 32'hFFFF0000, 32'h00000000, 2'd0, 2'd0, 16'h0100, 4'd1, 8'hA5, 1,0,2'd1,0,0);
    add(2, 8'h50,8'h50,8'h00,8'h00, 32'h00000000, 32'hFFFF0000, 32'h00000000, 2'd1, 2'd0, 16'h0100, 4'd1, 8'hA5, 1,0,2'd1,0,0);
    add(2, 8'h90,8'h90,8'h00,8'h00, 32'h00000000, 32'hFFFF0000, 32'h00000000, 2'd0, 2'd0, 16'h0100, 4'd1, 8'hA5, 1,0,2'd1,0,0);

    // Reset state.
    repeat (3) @(negedge clk);
    zero_v = '{n: 0, b: '{8'h00, 8'h00, 8'h00, 8'h00}, mn: 32'h0, mx: 32'h0, dc: 32'h0,
               ramp: 2'd0, dcen: 2'd0, rlen: 16'h0, rch: 4'd0, png: 8'h00,
               done: 1'b0, er: 1'b0, code: 2'd0, rs: 1'b0, pt: 1'b0};
    check_vec(99, zero_v);
    rst = 1'b0;

    // Table-driven frames, one idle cycle between frames.
    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) put(vecs[i].b[j]);
      idle();
      check_vec(i, vecs[i]);
    end

    // Back-to-back frames: RUN_RAMP ch1 then STOP ch1 with no gap.
    put(8'h51); put(8'h51); put(8'h91);
    chk("b2b.first_done", 64'(cmd_done), 64'd1);
    chk("b2b.first_ramp", 64'(ramp_enable), 64'd2);
    put(8'h91); idle();
    chk("b2b.second_done", 64'(cmd_done), 64'd1);
    chk("b2b.second_ramp", 64'(ramp_enable), 64'd0);

    // PING ch1: pong_trig is exactly one cycle wide.
    put(8'h11); put(8'h5A); put(8'h4B); idle();
    chk("ping.trig_hi", 64'(pong_trig), 64'd1);
    chk("ping.pong", 64'(pong), 64'h5A);
    @(negedge clk);
    chk("ping.trig_lo", 64'(pong_trig), 64'd0);
    chk("ping.done_lo", 64'(cmd_done), 64'd0);

    // Timeout after a partial SET_MAX; err must appear on the 50th idle cycle.
    put(8'h30); put(8'h11); idle();
    chk("tmo.busy_hi", 64'(busy), 64'd1);
    seen = 1'b0; k = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (err) seen = 1'b1;
    end
    chk("tmo.idle_cycles", 64'(k), 64'd50);
    chk("tmo.err_code", 64'(err_code), 64'd3);
    chk("tmo.busy_lo", 64'(busy), 64'd0);
    chk("tmo.set_max", 64'(set_max), 64'hFFFF0000);
    put(8'h70); put(8'h08); put(8'h00); put(8'h78); idle();
    chk("tmo.read_length", 64'(read_length), 64'h0008);
    chk("tmo.read_ch", 64'(read_ch), 64'd0);
    chk("tmo.read_start", 64'(read_start), 64'd1);
    @(negedge clk);
    chk("tmo.read_start_lo", 64'(read_start), 64'd0);

    // Reset in the middle of a frame clears everything without err.
    put(8'h21); put(8'h34);
    chk("rst.busy_mid", 64'(busy), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_vec(98, zero_v);
    @(negedge clk);
    rst = 1'b0;
    put(8'h21); put(8'h34); put(8'h12); put(8'h07); idle();
    chk("rst.after_set_min", 64'(set_min), 64'h12340000);
    chk("rst.after_done", 64'(cmd_done), 64'd1);
    chk("rst.after_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
